// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory controller.
//   - SZ_*   : req_size encodings (byte, half, word, illegal)
//   - state_e: controller FSM states (IDLE, WAIT, RESP)
//   - WCNT_W : width of the wait-state down-counter (WAIT_CYCLES up to 15)
//   - is_illegal_size(): flags the reserved size encoding
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int WCNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    function automatic logic is_illegal_size(input logic [1:0] size);
        return (size == SZ_ILL);
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/response bundle between the core memory stage
// (master) and the data-memory controller (slave).
//   req_valid/req_ready    : request handshake
//   req_write/size/unsigned/addr/wdata : request payload
//   rsp_valid/rsp_ready    : response handshake
//   rsp_rdata/rsp_err      : response payload
interface dmem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for one 32-bit word.
//   i_size, i_unsigned, i_addr_lo : access shape and byte offset in the word
//   i_old_word                    : current array contents of the target word
//   i_wdata                       : right-aligned store data
//   o_load_data                   : extracted and sign/zero-extended load result
//   o_store_word                  : i_old_word with the addressed lanes replaced
//   o_misalign                    : half on odd address or word not 4-aligned
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection for loads.
    always_comb begin
        w_byte = i_old_word[{i_addr_lo, 3'b000} +: 8];
        if (i_addr_lo[1]) begin
            w_half = i_old_word[31:16];
        end else begin
            w_half = i_old_word[15:0];
        end
    end

    // Load extension: the sign bit is forced to zero for unsigned loads.
    always_comb begin
        o_load_data = 32'h0000_0000;
        case (i_size)
            SZ_BYTE: o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            SZ_WORD: o_load_data = i_old_word;
            default: o_load_data = 32'h0000_0000;
        endcase
    end

    // Store merge: untouched lanes keep their old contents.
    always_comb begin
        o_store_word = i_old_word;
        case (i_size)
            SZ_BYTE: o_store_word[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            SZ_HALF: begin
                if (i_addr_lo[1]) begin
                    o_store_word[31:16] = i_wdata[15:0];
                end else begin
                    o_store_word[15:0] = i_wdata[15:0];
                end
            end
            SZ_WORD: o_store_word = i_wdata;
            default: o_store_word = i_old_word;
        endcase
    end

    // Alignment check; the illegal size is reported separately by the caller.
    always_comb begin
        o_misalign = 1'b0;
        case (i_size)
            SZ_HALF: o_misalign = i_addr_lo[0];
            SZ_WORD: o_misalign = (i_addr_lo != 2'b00);
            default: o_misalign = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data memory with byte/half/word access, valid/ready handshakes,
// configurable wait states and error reporting.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (array contents are not cleared)
//   bus   : dmem_ctrl_if slave modport (request in, response out)
// Single outstanding access. The access (store commit or load sample) happens
// on the clock edge that enters RESP; the response is held until rsp_ready.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'(S_IDLE);
    localparam logic [1:0] ST_WAIT = 2'(S_WAIT);
    localparam logic [1:0] ST_RESP = 2'(S_RESP);

    localparam logic [WCNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? WCNT_W'(WAIT_CYCLES - 1) : {WCNT_W{1'b0}};

    // state and latched request
    logic [1:0]        r_state;
    logic [WCNT_W-1:0] r_cnt;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_mem [DEPTH];

    // combinational
    logic              w_accept;
    logic              w_rsp_hs;
    logic [1:0]        w_state_nxt;
    logic [WCNT_W-1:0] w_cnt_nxt;
    logic              w_do_access;
    logic              w_acc_write;
    logic [1:0]        w_acc_size;
    logic              w_acc_unsigned;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [31:0]       w_acc_wdata;
    logic [IDX_W-1:0]  w_idx;
    logic [31:0]       w_old_word;
    logic [31:0]       w_load_data;
    logic [31:0]       w_store_word;
    logic              w_misalign;
    logic              w_oor;
    logic              w_err;
    logic              w_mem_we;

    // r_req_ready is only high in IDLE, so it doubles as the IDLE qualifier.
    assign w_accept = r_req_ready & bus.req_valid;
    assign w_rsp_hs = r_rsp_valid & bus.rsp_ready;

    // Operand select: with no wait states the access happens on the acceptance
    // edge, before the latches hold the request, so use the live bus then.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_acc_write    = bus.req_write;
            w_acc_size     = bus.req_size;
            w_acc_unsigned = bus.req_unsigned;
            w_acc_addr     = bus.req_addr;
            w_acc_wdata    = bus.req_wdata;
        end else begin
            w_acc_write    = r_write;
            w_acc_size     = r_size;
            w_acc_unsigned = r_unsigned;
            w_acc_addr     = r_addr;
            w_acc_wdata    = r_wdata;
        end
    end

    assign w_idx      = w_acc_addr[IDX_W+1:2];
    assign w_old_word = r_mem[w_idx];
    // Any set bit above the index field means word index >= DEPTH.
    assign w_oor      = |w_acc_addr[ADDR_W-1:IDX_W+2];
    assign w_err      = is_illegal_size(w_acc_size) | w_misalign | w_oor;
    assign w_mem_we   = w_do_access & w_acc_write & ~w_err;

    dmem_lane_align u_lane_align (
        .i_size       (w_acc_size),
        .i_unsigned   (w_acc_unsigned),
        .i_addr_lo    (w_acc_addr[1:0]),
        .i_old_word   (w_old_word),
        .i_wdata      (w_acc_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word),
        .o_misalign   (w_misalign)
    );

    // Next-state, wait counter and access strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_do_access = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES > 0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = CNT_LOAD;
                    end else begin
                        w_state_nxt = ST_RESP;
                        w_do_access = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == {WCNT_W{1'b0}}) begin
                    w_state_nxt = ST_RESP;
                    w_do_access = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - {{(WCNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                if (w_rsp_hs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = {WCNT_W{1'b0}};
            end
        endcase
    end

    // FSM, handshake outputs and response payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {WCNT_W{1'b0}};
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            if (w_do_access) begin
                r_rsp_rdata <= (!w_acc_write && !w_err) ? w_load_data : 32'h0000_0000;
                r_rsp_err   <= w_err;
            end
        end
    end

    // Request latch, captured on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write    <= 1'b0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_addr     <= {ADDR_W{1'b0}};
            r_wdata    <= 32'h0000_0000;
        end else if (w_accept) begin
            r_write    <= bus.req_write;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_addr     <= bus.req_addr;
            r_wdata    <= bus.req_wdata;
        end
    end

    // Storage array: no reset, written only on an error-free store access.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_store_word;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed test of dmem_ctrl with WAIT_CYCLES=0 (u_dut0) and
// WAIT_CYCLES=3 (u_dut3), each on its own interface and reset.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic clk;
    logic rst_n0;
    logic rst_n3;
    int   n_total;
    int   n_bad;

    dmem_ctrl_if #(.ADDR_W(32)) if0 ();
    dmem_ctrl_if #(.ADDR_W(32)) if3 ();

    dmem_ctrl #(.ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n0),
        .bus   (if0)
    );

    dmem_ctrl #(.ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n3),
        .bus   (if3)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? if3.req_ready : if0.req_ready;
    endfunction

    function automatic logic vld(input bit sel);
        return sel ? if3.rsp_valid : if0.rsp_valid;
    endfunction

    function automatic logic [31:0] rdat(input bit sel);
        return sel ? if3.rsp_rdata : if0.rsp_rdata;
    endfunction

    function automatic logic rerr(input bit sel);
        return sel ? if3.rsp_err : if0.rsp_err;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        if (sel) begin
            if3.req_valid = v; if3.req_write = wr; if3.req_size = sz;
            if3.req_unsigned = uns; if3.req_addr = addr; if3.req_wdata = wd;
        end else begin
            if0.req_valid = v; if0.req_write = wr; if0.req_size = sz;
            if0.req_unsigned = uns; if0.req_addr = addr; if0.req_wdata = wd;
        end
    endtask

    task automatic set_rr(input bit sel, input logic v);
        if (sel) begin
            if3.rsp_ready = v;
        end else begin
            if0.rsp_ready = v;
        end
    endtask

    // One full transaction: request, latency count, response checks,
    // optional stall with rsp_ready low, then the response handshake.
    task automatic run_acc(input bit sel, input string tag, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                           input int stall);
        int n;
        int lat;
        @(negedge clk);
        drive(sel, 1'b1, wr, sz, uns, addr, wd);
        n = 0;
        while (!rdy(sel) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk({tag, "_acc_timeout"}, 32'd1, 32'd0);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        lat = 1;
        while (!vld(sel) && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rd"}, rdat(sel), exp_rd);
        chk({tag, "_err"}, {31'd0, rerr(sel)}, {31'd0, exp_err});
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_stall_vld"}, {31'd0, vld(sel)}, 32'd1);
            chk({tag, "_stall_rd"}, rdat(sel), exp_rd);
            chk({tag, "_stall_err"}, {31'd0, rerr(sel)}, {31'd0, exp_err});
            chk({tag, "_stall_rdy"}, {31'd0, rdy(sel)}, 32'd0);
        end
        @(negedge clk);
        set_rr(sel, 1'b1);
        @(posedge clk);
        #1;
        set_rr(sel, 1'b0);
        chk({tag, "_vld_after"}, {31'd0, vld(sel)}, 32'd0);
        chk({tag, "_rdy_after"}, {31'd0, rdy(sel)}, 32'd1);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n0  = 1'b0;
        rst_n3  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        set_rr(1'b0, 1'b0);
        set_rr(1'b1, 1'b0);

        // reset values
        #12;
        chk("rst_req_ready", {31'd0, if0.req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, if0.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", if0.rsp_rdata, 32'h0);
        chk("rst_rsp_err",   {31'd0, if0.rsp_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n0 = 1'b1;
        rst_n3 = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", {31'd0, if0.req_ready}, 32'd1);

        // WAIT_CYCLES=0: main function
        run_acc(1'b0, "st_w10",  1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1, 0);
        run_acc(1'b0, "ld_w10",  1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1, 0);
        run_acc(1'b0, "ld_b11s", 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0,        32'hFFFFFFBE, 1'b0, 1, 0);
        run_acc(1'b0, "ld_b13s", 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 1, 0);
        run_acc(1'b0, "ld_b13u", 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0,        32'h000000DE, 1'b0, 1, 0);
        run_acc(1'b0, "ld_b10u", 1'b0, SZ_BYTE, 1'b1, 32'h10, 32'h0,        32'h000000EF, 1'b0, 1, 0);
        run_acc(1'b0, "ld_b12s", 1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0,        32'hFFFFFFAD, 1'b0, 1, 0);
        run_acc(1'b0, "ld_h12s", 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 1, 0);
        run_acc(1'b0, "ld_h10u", 1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, 1, 0);
        run_acc(1'b0, "st_b12",  1'b1, SZ_BYTE, 1'b0, 32'h12, 32'hFFFFFF55, 32'h0,        1'b0, 1, 0);
        run_acc(1'b0, "ld_w10b", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'hDE55BEEF, 1'b0, 1, 0);
        run_acc(1'b0, "st_h10",  1'b1, SZ_HALF, 1'b0, 32'h10, 32'hABCD1234, 32'h0,        1'b0, 1, 0);
        run_acc(1'b0, "ld_w10h", 1'b0, SZ_WORD, 1'b1, 32'h10, 32'h0,        32'hDE551234, 1'b0, 1, 0);

        // errors
        run_acc(1'b0, "st_w00",  1'b1, SZ_WORD, 1'b0, 32'h00,  32'hA5A5A5A5, 32'h0,        1'b0, 1, 0);
        run_acc(1'b0, "e_ld_w02",1'b0, SZ_WORD, 1'b0, 32'h02,  32'h0,        32'h0,        1'b1, 1, 0);
        run_acc(1'b0, "e_st_h01",1'b1, SZ_HALF, 1'b0, 32'h01,  32'h00007777, 32'h0,        1'b1, 1, 0);
        run_acc(1'b0, "ld_w00",  1'b0, SZ_WORD, 1'b0, 32'h00,  32'h0,        32'hA5A5A5A5, 1'b0, 1, 0);
        run_acc(1'b0, "e_ld_s11",1'b0, SZ_ILL,  1'b0, 32'h10,  32'h0,        32'h0,        1'b1, 1, 0);
        run_acc(1'b0, "e_st_s11",1'b1, SZ_ILL,  1'b0, 32'h10,  32'h99999999, 32'h0,        1'b1, 1, 0);
        run_acc(1'b0, "e_ld_400",1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1, 1, 0);
        run_acc(1'b0, "e_st_410",1'b1, SZ_WORD, 1'b0, 32'h410, 32'h12345678, 32'h0,        1'b1, 1, 0);
        run_acc(1'b0, "ld_w10e", 1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        32'hDE551234, 1'b0, 1, 0);

        // WAIT_CYCLES=3: latency and stall hold
        run_acc(1'b1, "w3_st20", 1'b1, SZ_WORD, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0,        1'b0, 4, 0);
        run_acc(1'b1, "w3_ld20", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0,        32'hCAFEF00D, 1'b0, 4, 4);

        // reset asserted while a store sits in WAIT
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11111111);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        chk("w3_wait_rdy", {31'd0, if3.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n3 = 1'b0;
        #1;
        chk("w3_rst_vld",  {31'd0, if3.rsp_valid}, 32'd0);
        chk("w3_rst_rd",   if3.rsp_rdata, 32'h0);
        chk("w3_rst_err",  {31'd0, if3.rsp_err}, 32'd0);
        chk("w3_rst_rdy",  {31'd0, if3.req_ready}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n3 = 1'b1;
        repeat (2) @(posedge clk);
        run_acc(1'b1, "w3_ld20r", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 4, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
